// File: rtl/rand_key_gen.sv
// rand_key_gen: pulls KEY_WIDTH/64 random words from the LFSR source and
// assembles them into an AES key. A word equal to the previous accepted word
// is dropped and re-requested, so a stuck source cannot produce a key of
// repeated words. The finished key is offered with a valid/ack handshake.
// KEY_WIDTH must be a multiple of 64 and at least 128.
module rand_key_gen #(
  parameter int KEY_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [63:0]          rand_data,
  output logic                 rand_ready,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 key_valid,
  input  logic                 key_ack,
  output logic                 busy,
  output logic [7:0]           reject_cnt
);

  localparam int WORDS  = KEY_WIDTH / 64;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [WCNT_W-1:0]     r_wcnt;
  logic                  r_have_prev;
  logic [63:0]           r_prev;
  // Only the words collected before the last one need storing; the last word
  // goes straight from rand_data into the key.
  logic [KEY_WIDTH-65:0] r_sh;
  logic [KEY_WIDTH-1:0]  r_key;
  logic [7:0]            r_reject_cnt;
  logic                  r_rand_ready;
  logic                  r_key_valid;
  logic                  r_busy;

  logic                  w_reject;
  logic                  w_last;
  logic [KEY_WIDTH-1:0]  w_shifted;

  assign w_reject  = r_have_prev && (rand_data == r_prev);
  assign w_last    = (r_wcnt == WCNT_W'(WORDS - 1));
  assign w_shifted = {r_sh, rand_data};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: one REQ/CAPT round trip per word, rejected words loop back.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = REQ;
        end
      end
      REQ: begin
        w_next = CAPT;
      end
      CAPT: begin
        if (w_reject) begin
          w_next = REQ;
        end else if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = REQ;
        end
      end
      DONE: begin
        if (key_ack) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Word collection, stuck-source guard, reject counting and key loading.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt       <= '0;
      r_have_prev  <= 1'b0;
      r_prev       <= '0;
      r_sh         <= '0;
      r_key        <= '0;
      r_reject_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_wcnt      <= '0;
            r_have_prev <= 1'b0;
          end
        end
        CAPT: begin
          if (w_reject) begin
            if (r_reject_cnt != 8'hFF) begin
              r_reject_cnt <= r_reject_cnt + 8'd1;
            end
          end else begin
            r_sh        <= w_shifted[KEY_WIDTH-65:0];
            r_prev      <= rand_data;
            r_have_prev <= 1'b1;
            if (w_last) begin
              r_key <= w_shifted;
            end else begin
              r_wcnt <= r_wcnt + WCNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rand_ready <= 1'b0;
      r_key_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rand_ready <= (w_next == REQ);
      r_key_valid  <= (w_next == DONE);
      r_busy       <= (w_next != IDLE);
    end
  end

  assign rand_ready = r_rand_ready;
  assign key_valid  = r_key_valid;
  assign busy       = r_busy;
  assign key        = r_key;
  assign reject_cnt = r_reject_cnt;

endmodule

// File: tb/tb_rand_key_gen.sv
// Testbench for rand_key_gen: a 128-bit instance driven by randomized and
// directed word streams with a scoreboard, plus a 256-bit instance checked
// with a directed sequence.
module tb_rand_key_gen;

  typedef struct {
    logic [127:0] key;
    int           rej;
    int           pulses;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         keyAck = 1'b0;
  logic [63:0]  randData = 64'd0;
  logic         randReady;
  logic [127:0] key;
  logic         keyValid;
  logic         busy;
  logic [7:0]   rejectCnt;

  logic         start256 = 1'b0;
  logic         keyAck256 = 1'b0;
  logic [63:0]  randData256 = 64'd0;
  logic         randReady256;
  logic [255:0] key256;
  logic         keyValid256;
  logic         busy256;
  logic [7:0]   rejectCnt256;

  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  int           startCyc = 0;
  int           pulseCnt = 0;
  int           pulseBase = 0;
  int           pulseCnt256 = 0;
  int           expRejTotal = 0;
  logic [63:0]  srcQ[$];
  logic [63:0]  srcQ256[$];
  exp_t         expQ[$];
  logic         prevValid = 1'b0;

  rand_key_gen #(.KEY_WIDTH(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rand_data  (randData),
    .rand_ready (randReady),
    .key        (key),
    .key_valid  (keyValid),
    .key_ack    (keyAck),
    .busy       (busy),
    .reject_cnt (rejectCnt)
  );

  rand_key_gen #(.KEY_WIDTH(256)) dut256 (
    .clk        (clk),
    .reset      (reset),
    .start      (start256),
    .rand_data  (randData256),
    .rand_ready (randReady256),
    .key        (key256),
    .key_valid  (keyValid256),
    .key_ack    (keyAck256),
    .busy       (busy256),
    .reject_cnt (rejectCnt256)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure start-to-valid latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Random source models: latch the next word whenever rand_ready is seen.
  always @(posedge clk) begin
    if (randReady) begin
      pulseCnt <= pulseCnt + 1;
      if (srcQ.size() > 0) randData <= srcQ.pop_front();
      else randData <= {$urandom, $urandom};
    end
  end

  always @(posedge clk) begin
    if (randReady256) begin
      pulseCnt256 <= pulseCnt256 + 1;
      if (srcQ256.size() > 0) randData256 <= srcQ256.pop_front();
      else randData256 <= {$urandom, $urandom};
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each new key_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (keyValid && !prevValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedKeyValid", 256'd1, 256'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("key", {128'd0, key}, {128'd0, e.key});
        checkOutput("rejectCnt", {248'd0, rejectCnt}, 256'(e.rej));
        checkOutput("pulses", 256'(pulseCnt - pulseBase), 256'(e.pulses));
        checkOutput("latency", 256'(cyc - startCyc), 256'(2 * e.pulses));
      end
    end
    prevValid <= keyValid;
  end

  // Builds the expected key from the word stream: a word matching the last
  // accepted word of this key is skipped, the first two survivors form the key.
  task automatic applyStimulus(input logic [63:0] words[$], input int hold, input bit startInDone);
    exp_t        e;
    logic [63:0] last = 64'd0;
    bit          haveLast = 0;
    int          accepted = 0;
    int          rej = 0;
    bit          seen = 0;
    e.key = '0;
    e.pulses = 0;
    foreach (words[i]) begin
      if (accepted < 2) begin
        e.pulses++;
        if (haveLast && words[i] == last) begin
          rej++;
        end else begin
          e.key = {e.key[63:0], words[i]};
          last = words[i];
          haveLast = 1;
          accepted++;
        end
      end
    end
    expRejTotal = (expRejTotal + rej > 255) ? 255 : expRejTotal + rej;
    e.rej = expRejTotal;
    foreach (words[i]) srcQ.push_back(words[i]);
    expQ.push_back(e);
    start = 1'b1;
    startCyc = cyc + 1;
    pulseBase = pulseCnt;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (keyValid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checkOutput("keyValidTimeout", 256'd0, 256'd1);
      expQ.delete();
      srcQ.delete();
    end else begin
      for (int i = 0; i < hold; i++) begin
        start = (startInDone && i == 3);
        @(negedge clk);
        start = 1'b0;
        checkOutput("holdValid", {255'd0, keyValid}, 256'd1);
        checkOutput("holdKey", {128'd0, key}, {128'd0, e.key});
        checkOutput("holdNoReady", {255'd0, randReady}, 256'd0);
      end
      keyAck = 1'b1;
      @(negedge clk);
      keyAck = 1'b0;
      checkOutput("validAfterAck", {255'd0, keyValid}, 256'd0);
      checkOutput("busyAfterAck", {255'd0, busy}, 256'd0);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Key"}, {128'd0, key}, 256'd0);
    checkOutput({tag, "Valid"}, {255'd0, keyValid}, 256'd0);
    checkOutput({tag, "Ready"}, {255'd0, randReady}, 256'd0);
    checkOutput({tag, "Busy"}, {255'd0, busy}, 256'd0);
    checkOutput({tag, "RejCnt"}, {248'd0, rejectCnt}, 256'd0);
  endtask

  initial begin
    logic [63:0] w[$];
    logic [63:0] lastW;
    int          n;
    int          acc;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 1'b1;
    @(negedge clk);

    // Basic 128-bit key.
    w = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD};
    applyStimulus(w, 0, 0);

    // Repeated words are rejected.
    w = '{64'h1234, 64'h1234, 64'h1234, 64'hABCD};
    applyStimulus(w, 1, 0);

    // Long hold in DONE with a start pulse that must be ignored.
    w = '{64'h0, 64'h0, 64'h1};
    applyStimulus(w, 10, 1);

    // Reset during the second capture.
    srcQ.push_back(64'hAAAA);
    srcQ.push_back(64'hBBBB);
    srcQ.push_back(64'hCCCC);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = pulseCnt;
    for (int i = 0; i < 20 && pulseCnt - n < 2; i++) @(negedge clk);
    reset = 1'b0;
    #1;
    checkResetState("midReset");
    repeat (2) @(negedge clk);
    srcQ.delete();
    reset = 1'b1;
    expRejTotal = 0;
    @(negedge clk);
    checkResetState("afterReset");
    w = '{64'hCAFE, 64'hF00D};
    applyStimulus(w, 0, 0);

    // Randomized word streams with random repeats.
    for (int k = 0; k < 8; k++) begin
      w.delete();
      acc = 0;
      lastW = 64'd0;
      while (acc < 2) begin
        if (acc > 0 && $urandom_range(0, 2) == 0) begin
          w.push_back(lastW);
        end else begin
          lastW = {$urandom, $urandom};
          w.push_back(lastW);
          acc++;
        end
      end
      applyStimulus(w, $urandom_range(0, 3), 0);
    end

    // 256-bit instance: words 1..4, valid 8 cycles after start.
    srcQ256 = '{64'd1, 64'd2, 64'd3, 64'd4};
    n = pulseCnt256;
    start256 = 1'b1;
    @(negedge clk);
    start256 = 1'b0;
    acc = 0;
    while (!keyValid256 && acc < 100) begin
      @(negedge clk);
      acc++;
    end
    checkOutput("latency256", 256'(acc), 256'd8);
    checkOutput("key256", key256, {64'd1, 64'd2, 64'd3, 64'd4});
    checkOutput("pulses256", 256'(pulseCnt256 - n), 256'd4);
    keyAck256 = 1'b1;
    @(negedge clk);
    keyAck256 = 1'b0;
    checkOutput("validAfterAck256", {255'd0, keyValid256}, 256'd0);

    // Stuck source: reject counter saturates, then a new word completes the key.
    w.delete();
    w.push_back(64'h5);
    for (int i = 0; i < 300; i++) w.push_back(64'h5);
    w.push_back(64'h6);
    applyStimulus(w, 0, 0);

    // Counter stays saturated on further rejects.
    w = '{64'h77, 64'h77, 64'h88};
    applyStimulus(w, 0, 0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", 256'(expQ.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rand_key_gen.md
# rand_key_gen

Downstream consumer of the 64-bit LFSR random source. On a `start` request it pulls `KEY_WIDTH/64` fresh random words by pulsing `rand_ready`, and rejects any word equal to the previous accepted word (stuck-source guard). It then presents the concatenated value as an AES key with a valid/ack handshake. It sits between the random source and the AES key-expansion input.

## Interface
- `KEY_WIDTH`, default 128, key width in bits. Must be a multiple of 64 and ≥ 128 (128/192/256 used). `WORDS = KEY_WIDTH/64`.
- `clk` input, 1 bit: single clock, all logic rising-edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a new key. Sampled only in IDLE.
- `rand_data` input, 64 bits: registered random word from the source (`outData`).
- `rand_ready` output, 1 bit: one-cycle pulse; source latches a new word on the same edge.
- `key` output, `KEY_WIDTH` bits: last completed key. First accepted word is in the MSBs.
- `key_valid` output, 1 bit: `key` is new and unconsumed.
- `key_ack` input, 1 bit: consumer accepts `key`. Meaningful only while `key_valid`=1.
- `busy` output, 1 bit: high in any state other than IDLE.
- `reject_cnt` output, 8 bits: count of rejected words. Saturates at 255 and is cleared only by reset.

## Operation
- States: IDLE, REQ, CAPT, DONE.
- IDLE
  - `busy`=0.
  - If `start`=1: go to REQ, clear the word counter `wcnt` to 0, clear the `have_prev` flag.
- REQ
  - Drive `rand_ready`=1 for exactly this cycle, then go to CAPT.
- CAPT
  - `rand_data` now holds the word latched at the REQ→CAPT edge. Sample it at the end of this cycle.
  - If `have_prev`=1 and `rand_data`==`prev`: reject the word.
    - Increment `reject_cnt` if it is below 255.
    - Go to REQ. `wcnt` is unchanged.
  - Otherwise accept the word:
    - Shift into the internal register: `sh <= {sh[KEY_WIDTH-65:0], rand_data}`.
    - `prev <= rand_data`, `have_prev <= 1`.
    - If `wcnt`==`WORDS-1`: load `key <= {sh[KEY_WIDTH-65:0], rand_data}` and go to DONE.
    - Else: `wcnt` += 1 and go to REQ.
- DONE
  - `key_valid`=1 and `key` is stable.
  - On `key_ack`=1: go to IDLE. `key_valid` drops after that edge.
  - `key` keeps its value until the next completion.
- `start` is ignored whenever `busy`=1; it is not queued. `key_ack` outside DONE is ignored.
- Word equality is a full 64-bit compare. An all-zero word is accepted unless it repeats the previous word.
- `wcnt` width is `$clog2(WORDS)`, minimum 1 bit.

## Timing
- Reset (async, `reset`=0):
  - state=IDLE.
  - `rand_ready`=0, `key_valid`=0, `busy`=0.
  - `key`=0, `reject_cnt`=0, `sh`=0, `prev`=0, `have_prev`=0, `wcnt`=0.
- Reset asserted mid-operation aborts immediately. The partial key is discarded, and `key` returns to 0 even if a previous key was valid.
- `rand_ready`, `key_valid` and `busy` are registered, decoded from state. They are not combinational from inputs.
- Latency with no rejects:
  - `start` sampled at edge E0.
  - `rand_ready` is high in the cycles after E0, E2, …, E(2·WORDS−2).
  - `key_valid` rises after edge E(2·WORDS): 4 cycles for 128-bit, 8 cycles for 256-bit.
- Each rejected word adds 2 cycles.
- Ack in the first `key_valid` cycle: `key_valid` is high for exactly 1 cycle. A new `start` is accepted at the earliest 1 cycle after the ack edge, from IDLE.
- Throughput is at best one 128-bit key per 6 cycles: 4 cycles of collection, 1 DONE cycle with immediate ack, 1 IDLE cycle.

## Test plan
- **Basic 128-bit key:** bench model returns 0xFFFF_FFFF_FFFF_FFFE, then 0xFFFF_FFFF_FFFF_FFFD, latched on `rand_ready`.
  - Required: `key`=0xFFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFD.
  - `key_valid` rises 4 cycles after the `start` edge.
  - Exactly 2 `rand_ready` pulses, `reject_cnt`=0.
- **Reject:** words 0x1234, 0x1234, 0x1234, 0xABCD.
  - Required: `key`={0x1234, 0xABCD} (each word zero-extended to 64 bits).
  - `reject_cnt`=2, 4 `rand_ready` pulses.
  - `key_valid` rises 8 cycles after start.
- **Handshake hold:** hold `key_ack`=0 for 10 cycles, and pulse `start` during DONE.
  - Required: `key_valid` and `key` stable throughout, no `rand_ready`, `start` ignored.
  - `key_ack`=1 → `key_valid`=0 next cycle, `busy`=0.
- **Reset mid-collection:** drop `reset` during the second CAPT.
  - Required: all outputs at reset values while `reset`=0 and after release, `key`=0.
  - A following `start` produces a full fresh key.
- **KEY_WIDTH=256:** words 1, 2, 3, 4.
  - Required: `key`={64'd1, 64'd2, 64'd3, 64'd4}.
  - 4 pulses, `key_valid` at +8 cycles.
- **Saturation:** constant word 0x5 after the first accept, for 300 requests.
  - Required: `reject_cnt` stops at 255, FSM keeps cycling REQ/CAPT, no `key_valid`.
